// File: rtl/wb_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter2
//   Two-master round-robin arbiter for a classic (B3) Wishbone slave bus, with
//   a bus watchdog that turns a silent slave into an err for the owning master.
//   m0 is the picorv32 core; m1 is the HPS-side debug/bridge master.
//
// Handshake: a master requests and holds the bus with cyc. A beat is offered
// while cyc & stb are high and completes in the cycle ack or err is high.
// The owner keeps the bus for as long as its cyc stays high, so locked and
// multi-beat cycles are never split between masters.
//
// Ports
//   wb_clk, wb_rst          bus clock, asynchronous active-high reset
//   m0_*_i / m0_*_o         master 0 request side / response side
//   m1_*_i / m1_*_o         master 1 request side / response side
//   s_*_o / s_*_i           shared slave bus
//   grant_o                 registered FSM state, one-hot owner (bit0 = m0),
//                           00 = idle; doubles as the FSM debug view
//   timeout_o               one-cycle pulse when the watchdog aborts a beat
// -----------------------------------------------------------------------------
module wb_rr_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  // Counter must hold TIMEOUT itself; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam bit WD_ON = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic          last;      // index of the master that owned the bus last
  logic [CW-1:0] wd_cnt;
  logic          own_cyc, own_stb;
  logic          wd_wait, wd_err;

  // Next-state: a grant always passes through IDLE, giving one dead cycle
  // between owners.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_nxt = OWN0;
        else if (m1_cyc_i)        state_nxt = OWN1;
      end
      OWN0:    if (!m0_cyc_i) state_nxt = IDLE;
      OWN1:    if (!m1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Routing and responses, all combinational from the registered owner.
  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    s_we_o   = m0_we_i;
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    if (state == OWN1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      own_cyc = m1_cyc_i;
      own_stb = m1_stb_i;
    end else if (state == OWN0) begin
      own_cyc = m0_cyc_i;
      own_stb = m0_stb_i;
    end

    // Beat outstanding with no response this cycle. A response arriving on
    // the deadline cycle suppresses the watchdog.
    wd_wait = own_cyc && own_stb && !s_ack_i && !s_err_i;
    wd_err  = WD_ON && wd_wait && (wd_cnt == TO_VAL);

    // On a watchdog abort the slave sees the cycle withdrawn.
    s_cyc_o = own_cyc && !wd_err;
    s_stb_o = own_stb && !wd_err;

    m0_ack_o  = (state == OWN0) && s_ack_i;
    m0_err_o  = (state == OWN0) && (s_err_i || wd_err);
    m1_ack_o  = (state == OWN1) && s_ack_i;
    m1_err_o  = (state == OWN1) && (s_err_i || wd_err);
    m0_dat_o  = s_dat_i;
    m1_dat_o  = s_dat_i;
    timeout_o = wd_err;
    grant_o   = state;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state  <= IDLE;
      last   <= 1'b1;   // first contest after reset goes to m0
      wd_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == OWN0 && !m0_cyc_i) last <= 1'b0;
      if (state == OWN1 && !m1_cyc_i) last <= 1'b1;

      if (state_nxt != state || s_ack_i || s_err_i || wd_err)
        wd_cnt <= '0;
      else if (WD_ON && wd_wait)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter2
//   Directed bench for wb_rr_arbiter2 with TIMEOUT = 8. Inputs are driven just
//   after each falling clock edge and outputs sampled 1 ns later, so registered
//   outputs reflect the preceding rising edge and combinational outputs
//   reflect the inputs of the current cycle.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  always #5 wb_clk = ~wb_clk;

  logic [AW-1:0] m0_adr_i = '0, m1_adr_i = '0, s_adr_o;
  logic [DW-1:0] m0_dat_i = '0, m1_dat_i = '0, s_dat_o, s_dat_i = '0;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic [SW-1:0] m0_sel_i = '0, m1_sel_i = '0, s_sel_o;
  logic m0_we_i = 0, m0_cyc_i = 0, m0_stb_i = 0, m0_ack_o, m0_err_o;
  logic m1_we_i = 0, m1_cyc_i = 0, m1_stb_i = 0, m1_ack_o, m1_err_o;
  logic s_we_o, s_cyc_o, s_stb_o, s_ack_i = 0, s_err_i = 0;
  logic [1:0] grant_o;
  logic timeout_o;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected owner order for the round-robin scenario
  logic [1:0] exp_q[$];

  wb_rr_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge wb_clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m0(input logic cyc, input logic stb);
    m0_cyc_i = cyc;
    m0_stb_i = stb;
  endtask

  task automatic drive_m1(input logic cyc, input logic stb);
    m1_cyc_i = cyc;
    m1_stb_i = stb;
  endtask

  task automatic apply_reset();
    tick();
    wb_rst = 1'b1;
    drive_m0(0, 0);
    drive_m1(0, 0);
    s_ack_i = 0;
    s_err_i = 0;
    tick();
    wb_rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick();
    settle();
    checks++;
    if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant_o); end
    checks++;
    if ({s_cyc_o, s_stb_o, timeout_o} !== 3'b000) begin
      errors++; $display("FAIL reset_bus: cyc/stb/timeout got %b want 000", {s_cyc_o, s_stb_o, timeout_o});
    end
    checks++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_resp: ack/err got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    end
    wb_rst = 1'b0;
  endtask

  task automatic test_single_read();
    m0_adr_i = 32'h0000_0100;
    m0_we_i  = 1'b0;
    m0_sel_i = 4'hF;
    m1_adr_i = 32'h0000_0200;
    tick();
    drive_m0(1, 1);
    settle();
    checks++;
    if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL read_latency: grant=%b cyc=%b want 00/0", grant_o, s_cyc_o);
    end
    tick();
    settle();
    checks++;
    if (grant_o !== 2'b01 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) begin
      errors++; $display("FAIL read_grant: grant=%b cyc=%b stb=%b want 01/1/1", grant_o, s_cyc_o, s_stb_o);
    end
    checks++;
    if (s_adr_o !== 32'h0000_0100 || s_sel_o !== 4'hF) begin
      errors++; $display("FAIL read_route: adr=%h sel=%h want 00000100/f", s_adr_o, s_sel_o);
    end
    tick();
    settle();
    checks++;
    if (m0_ack_o !== 1'b0) begin errors++; $display("FAIL read_early_ack: got %b want 0", m0_ack_o); end
    tick();
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    settle();
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_ack: ack=%b dat=%h want 1/deadbeef", m0_ack_o, m0_dat_o);
    end
    checks++;
    if (m1_ack_o !== 1'b0 || m1_err_o !== 1'b0 || m1_dat_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_other: m1 ack=%b err=%b dat=%h want 0/0/deadbeef", m1_ack_o, m1_err_o, m1_dat_o);
    end
    tick();
    s_ack_i = 1'b0;
    drive_m0(0, 0);
    settle();
    checks++;
    if (grant_o !== 2'b01) begin errors++; $display("FAIL read_hold: grant=%b want 01", grant_o); end
    tick();
    settle();
    checks++;
    if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      errors++; $display("FAIL read_release: grant=%b cyc=%b want 00/0", grant_o, s_cyc_o);
    end
  endtask

  task automatic test_round_robin();
    int rem0 = 3;
    int rem1 = 3;
    logic [1:0] e;
    logic [1:0] g;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b10);
    end
    tick();
    drive_m0(1, 1);
    drive_m1(1, 1);
    settle();
    checks++;
    if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_latency: grant=%b want 00", grant_o); end
    for (int k = 0; k < 6; k++) begin
      tick();
      e = exp_q.pop_front();
      g = grant_o;
      s_ack_i = 1'b1;
      s_dat_i = 32'h1000 + k;
      settle();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rr_order[%0d]: grant=%b want %b", k, g, e); end
      checks++;
      if (m0_ack_o !== (e == 2'b01) || m1_ack_o !== (e == 2'b10)) begin
        errors++; $display("FAIL rr_ack[%0d]: m0_ack=%b m1_ack=%b owner %b", k, m0_ack_o, m1_ack_o, e);
      end
      tick();
      s_ack_i = 1'b0;
      if (g == 2'b10) begin drive_m1(0, 0); rem1--; end
      else begin drive_m0(0, 0); rem0--; end
      tick();
      settle();
      checks++;
      if (grant_o !== 2'b00) begin errors++; $display("FAIL rr_idle_gap[%0d]: grant=%b want 00", k, grant_o); end
      if (g == 2'b10 && rem1 > 0) drive_m1(1, 1);
      if (g != 2'b10 && rem0 > 0) drive_m0(1, 1);
    end
    drive_m0(0, 0);
    drive_m1(0, 0);
    tick();
  endtask

  task automatic test_back_to_back_burst();
    tick();
    drive_m1(1, 1);
    tick();
    drive_m0(1, 1);
    s_ack_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_dat_i = 32'hB000 + b;
      settle();
      checks++;
      if (grant_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || s_adr_o !== 32'h0000_0200) begin
        errors++; $display("FAIL burst_beat[%0d]: grant=%b m1_ack=%b m0_ack=%b adr=%h", b, grant_o, m1_ack_o, m0_ack_o, s_adr_o);
      end
      tick();
    end
    s_ack_i = 1'b0;
    drive_m1(0, 0);
    settle();
    checks++;
    if (grant_o !== 2'b10) begin errors++; $display("FAIL burst_hold: grant=%b want 10", grant_o); end
    tick();
    settle();
    checks++;
    if (grant_o !== 2'b00 || m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
      errors++; $display("FAIL burst_gap: grant=%b m0 ack=%b err=%b want 00/0/0", grant_o, m0_ack_o, m0_err_o);
    end
    tick();
    settle();
    checks++;
    if (grant_o !== 2'b01 || s_adr_o !== 32'h0000_0100) begin
      errors++; $display("FAIL burst_handoff: grant=%b adr=%h want 01/00000100", grant_o, s_adr_o);
    end
    tick();
    drive_m0(0, 0);
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    tick();
    drive_m0(1, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      settle();
      checks++;
      if (m0_err_o !== 1'b0 || timeout_o !== 1'b0 || s_stb_o !== 1'b1) begin
        errors++; $display("FAIL wd_wait[%0d]: err=%b timeout=%b stb=%b want 0/0/1", i, m0_err_o, timeout_o, s_stb_o);
      end
    end
    tick();
    settle();
    checks++;
    if (m0_err_o !== 1'b1 || timeout_o !== 1'b1 || m1_err_o !== 1'b0) begin
      errors++; $display("FAIL wd_fire: m0_err=%b timeout=%b m1_err=%b want 1/1/0", m0_err_o, timeout_o, m1_err_o);
    end
    checks++;
    if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b0 || grant_o !== 2'b01) begin
      errors++; $display("FAIL wd_abort: stb=%b cyc=%b grant=%b want 0/0/01", s_stb_o, s_cyc_o, grant_o);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      settle();
      checks++;
      if (timeout_o !== 1'b0 || s_stb_o !== 1'b1) begin
        errors++; $display("FAIL wd_restart[%0d]: timeout=%b stb=%b want 0/1", i, timeout_o, s_stb_o);
      end
    end
    tick();
    settle();
    checks++;
    if (timeout_o !== 1'b1 || m0_err_o !== 1'b1) begin
      errors++; $display("FAIL wd_refire: timeout=%b err=%b want 1/1", timeout_o, m0_err_o);
    end
    tick();
    drive_m0(0, 0);
    tick();
    settle();
    checks++;
    if (grant_o !== 2'b00) begin errors++; $display("FAIL wd_release: grant=%b want 00", grant_o); end
  endtask

  task automatic test_ack_vs_timeout();
    tick();
    drive_m0(1, 1);
    for (int i = 1; i <= 8; i++) tick();
    tick();
    s_ack_i = 1'b1;
    settle();
    checks++;
    if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0 || timeout_o !== 1'b0 || s_stb_o !== 1'b1) begin
      errors++; $display("FAIL ack_wins: ack=%b err=%b timeout=%b stb=%b want 1/0/0/1", m0_ack_o, m0_err_o, timeout_o, s_stb_o);
    end
    tick();
    s_ack_i = 1'b0;
    drive_m0(0, 0);
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    tick();
    drive_m1(1, 1);
    tick();
    settle();
    checks++;
    if (grant_o !== 2'b10 || s_cyc_o !== 1'b1) begin
      errors++; $display("FAIL arst_pre: grant=%b cyc=%b want 10/1", grant_o, s_cyc_o);
    end
    #2;
    wb_rst = 1'b1;
    #1;
    checks++;
    if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      errors++; $display("FAIL arst_drop: grant=%b cyc=%b stb=%b want 00/0/0", grant_o, s_cyc_o, s_stb_o);
    end
    tick();
    tick();
    wb_rst = 1'b0;
    drive_m0(1, 1);
    drive_m1(1, 1);
    tick();
    settle();
    checks++;
    if (grant_o !== 2'b01) begin errors++; $display("FAIL arst_first_contest: grant=%b want 01", grant_o); end
    drive_m0(0, 0);
    drive_m1(0, 0);
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back_burst();
    test_watchdog();
    test_ack_vs_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL sim_timeout: bench exceeded time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
